// File: rtl/snitch_ro_line_buffer.sv
// Fully-associative read-only line buffer with multi-range cacheability,
// optional next-line prefetch, single-cycle flush and hit/miss counters.
module snitch_ro_line_buffer #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned LineWidth      = 128,
    parameter int unsigned NrEntries      = 4,
    parameter int unsigned NrAddrRules    = 1,
    parameter bit          EnablePrefetch = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  enable_i,
    input  logic                                  prefetch_en_i,
    input  logic                                  flush_valid_i,
    output logic                                  flush_ready_o,
    input  logic [NrAddrRules-1:0][AddrWidth-1:0] start_addr_i,
    input  logic [NrAddrRules-1:0][AddrWidth-1:0] end_addr_i,
    input  logic [AddrWidth-1:0]                  req_addr_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    output logic [DataWidth-1:0]                  rsp_data_o,
    output logic                                  rsp_error_o,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [AddrWidth-1:0]                  refill_addr_o,
    output logic                                  refill_valid_o,
    input  logic                                  refill_ready_i,
    input  logic [LineWidth-1:0]                  refill_data_i,
    input  logic                                  refill_error_i,
    input  logic                                  refill_rsp_valid_i,
    output logic                                  refill_rsp_ready_o,
    output logic [31:0]                           hit_count_o,
    output logic [31:0]                           miss_count_o
);

    localparam int unsigned OffW     = $clog2(LineWidth / 8);
    localparam int unsigned WordOffW = $clog2(DataWidth / 8);
    localparam int unsigned TagW     = AddrWidth - OffW;
    localparam int unsigned NrWords  = LineWidth / DataWidth;
    localparam int unsigned SelW     = (NrWords > 1) ? $clog2(NrWords) : 1;
    localparam int unsigned PtrW     = $clog2(NrEntries);

    typedef enum logic [2:0] {
        Idle, RefillReq, RefillWait, BypassReq, BypassWait, PrefReq, PrefWait
    } state_e;

    state_e state_q, state_d;

    logic                 rst_done_q;
    logic [NrEntries-1:0] valid_q;
    logic [TagW-1:0]      tag_q  [NrEntries];
    logic [LineWidth-1:0] data_q [NrEntries];
    logic [PtrW-1:0]      ptr_q;
    logic [TagW-1:0]      line_q;
    logic [SelW-1:0]      sel_q;
    logic                 rsp_valid_q, rsp_error_q;
    logic [DataWidth-1:0] rsp_data_q;
    logic [31:0]          hit_q, miss_q;

    logic                 accept, flush_acc, rsp_load, alloc, pf_go;
    logic                 hit, next_resident, req_cacheable, next_cacheable;
    logic [LineWidth-1:0] hit_line;
    logic [TagW-1:0]      req_tag, next_tag;
    logic [SelW-1:0]      req_sel;
    logic [AddrWidth-1:0] next_addr;
    logic [PtrW-1:0]      ptr_next;

    function automatic logic in_rules(input logic [AddrWidth-1:0] a,
                                      input logic [NrAddrRules-1:0][AddrWidth-1:0] s,
                                      input logic [NrAddrRules-1:0][AddrWidth-1:0] e);
        in_rules = 1'b0;
        for (int unsigned r = 0; r < NrAddrRules; r++) begin
            if (a >= s[r] && a < e[r]) in_rules = 1'b1;
        end
    endfunction

    function automatic logic [DataWidth-1:0] pick(input logic [LineWidth-1:0] l,
                                                  input logic [SelW-1:0] s);
        pick = '0;
        for (int unsigned w = 0; w < NrWords; w++) begin
            if (SelW'(w) == s) pick = l[w*DataWidth +: DataWidth];
        end
    endfunction

    assign req_tag        = req_addr_i[AddrWidth-1:OffW];
    assign req_sel        = (NrWords > 1) ? SelW'(req_addr_i >> WordOffW) : '0;
    assign next_tag       = line_q + TagW'(1);
    assign next_addr      = {next_tag, {OffW{1'b0}}};
    assign req_cacheable  = enable_i && in_rules(req_addr_i, start_addr_i, end_addr_i);
    assign next_cacheable = enable_i && in_rules(next_addr, start_addr_i, end_addr_i);
    assign ptr_next       = (ptr_q == PtrW'(NrEntries - 1)) ? '0 : ptr_q + PtrW'(1);

    // Residency of the next line ignores the entry about to be overwritten.
    always_comb begin
        hit           = 1'b0;
        hit_line      = '0;
        next_resident = 1'b0;
        for (int unsigned i = 0; i < NrEntries; i++) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit      = 1'b1;
                hit_line = data_q[i];
            end
            if (valid_q[i] && tag_q[i] == next_tag &&
                (refill_error_i || PtrW'(i) != ptr_q)) begin
                next_resident = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= Idle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        flush_ready_o      = 1'b0;
        refill_valid_o     = 1'b0;
        refill_rsp_ready_o = 1'b0;
        accept             = 1'b0;
        flush_acc          = 1'b0;
        rsp_load           = 1'b0;
        alloc              = 1'b0;
        pf_go              = 1'b0;
        unique case (state_q)
            Idle: begin
                flush_ready_o = rst_done_q && !rsp_valid_q;
                req_ready_o   = rst_done_q && !flush_valid_i && (!rsp_valid_q || rsp_ready_i);
                flush_acc     = flush_valid_i && flush_ready_o;
                accept        = req_valid_i && req_ready_o;
                if (accept && !req_cacheable)  state_d = BypassReq;
                else if (accept && !hit)       state_d = RefillReq;
            end
            RefillReq, BypassReq, PrefReq: begin
                refill_valid_o = 1'b1;
                if (refill_ready_i) begin
                    state_d = (state_q == RefillReq) ? RefillWait :
                              (state_q == BypassReq) ? BypassWait : PrefWait;
                end
            end
            RefillWait, BypassWait, PrefWait: begin
                refill_rsp_ready_o = 1'b1;
                if (refill_rsp_valid_i) begin
                    rsp_load = (state_q != PrefWait);
                    alloc    = (state_q != BypassWait) && !refill_error_i;
                    pf_go    = (state_q == RefillWait) && EnablePrefetch && prefetch_en_i &&
                               !refill_error_i && next_cacheable && !next_resident;
                    state_d  = pf_go ? PrefReq : Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_done_q  <= 1'b0;
            valid_q     <= '0;
            ptr_q       <= '0;
            line_q      <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (rsp_valid_q && rsp_ready_i) rsp_valid_q <= 1'b0;
            if (accept) begin
                line_q <= req_tag;
                sel_q  <= req_sel;
                if (req_cacheable && hit) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= pick(hit_line, req_sel);
                    rsp_error_q <= 1'b0;
                    if (hit_q != '1) hit_q <= hit_q + 32'd1;
                end
                if (req_cacheable && !hit && miss_q != '1) miss_q <= miss_q + 32'd1;
            end
            if (flush_acc) begin
                valid_q <= '0;
                ptr_q   <= '0;
            end
            if (rsp_load) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= pick(refill_data_i, sel_q);
                rsp_error_q <= refill_error_i;
            end
            if (alloc) begin
                valid_q[ptr_q] <= 1'b1;
                ptr_q          <= ptr_next;
            end
            if (pf_go) line_q <= next_tag;
        end
    end

    // Line storage carries no reset; valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tag_q[ptr_q]  <= line_q;
            data_q[ptr_q] <= refill_data_i;
        end
    end

    assign refill_addr_o = {line_q, {OffW{1'b0}}};
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_error_o   = rsp_error_q;
    assign hit_count_o   = hit_q;
    assign miss_count_o  = miss_q;

endmodule

// File: tb/tb_snitch_ro_line_buffer.sv
// Scoreboard bench for snitch_ro_line_buffer: line data encodes its own byte
// addresses, so each expected word equals its word-aligned request address.
module tb_snitch_ro_line_buffer;

    localparam int HIT = 0, MISS = 1, BYP = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        enable, prefetch_en, flush_valid, flush_ready;
    logic [0:0][31:0] start_addr, end_addr;
    logic [31:0] req_addr;
    logic        req_valid, req_ready;
    logic [31:0] rsp_data;
    logic        rsp_error, rsp_valid, rsp_ready;
    logic [31:0] refill_addr;
    logic        refill_valid, refill_ready;
    logic [127:0] refill_data;
    logic        refill_error, refill_rsp_valid, refill_rsp_ready;
    logic [31:0] hit_count, miss_count;

    int          checks = 0, errors = 0;
    int          exp_hit = 0, exp_miss = 0;
    logic [32:0] exp_q [$];
    logic [31:0] exp_refill [$];
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;

    always #5 clk = ~clk;

    snitch_ro_line_buffer dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .prefetch_en_i(prefetch_en),
        .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .rsp_data_o(rsp_data), .rsp_error_o(rsp_error), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .refill_addr_o(refill_addr), .refill_valid_o(refill_valid), .refill_ready_i(refill_ready),
        .refill_data_i(refill_data), .refill_error_i(refill_error),
        .refill_rsp_valid_i(refill_rsp_valid), .refill_rsp_ready_o(refill_rsp_ready),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", rsp_data, 32'hFFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e[31:0]);
                check("rsp_error", 32'(rsp_error), 32'(e[32]));
            end
        end
    end

    // Refill port model
    initial begin
        refill_ready = 1'b0; refill_rsp_valid = 1'b0; refill_data = '0; refill_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && refill_valid) begin
                logic [31:0] a;
                int n;
                a = refill_addr;
                if (exp_refill.size() == 0) check("unexpected_refill", a, 32'hFFFF_FFFF);
                else                        check("refill_addr", a, exp_refill.pop_front());
                refill_ready = 1'b1;
                @(negedge clk);
                refill_ready = 1'b0;
                @(negedge clk);
                for (int w = 0; w < 4; w++) refill_data[w*32 +: 32] = a + 32'(4 * w);
                refill_error     = err_en && (a == err_addr);
                refill_rsp_valid = 1'b1;
                n = 0;
                while (!refill_rsp_ready && n < 100) begin @(negedge clk); n++; end
                if (n >= 100) check("refill_rsp_timeout", 32'(n), 32'd0);
                @(posedge clk);
                #1 refill_rsp_valid = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || exp_refill.size() != 0 || !req_ready || rsp_valid) && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 500) check("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input int kind, input bit pf, input bit err);
        int n;
        exp_q.push_back({err, a & 32'hFFFF_FFFC});
        if (kind != HIT) exp_refill.push_back(a & 32'hFFFF_FFF0);
        if (pf)          exp_refill.push_back((a & 32'hFFFF_FFF0) + 32'h10);
        if (kind == HIT)  exp_hit++;
        if (kind == MISS) exp_miss++;
        @(negedge clk); req_addr = a; req_valid = 1'b1; #1;
        n = 0;
        while (!req_ready && n < 500) begin @(negedge clk); #1; n++; end
        if (n >= 500) check("req_accept_timeout", 32'(n), 32'd0);
        @(negedge clk); req_valid = 1'b0; #1;
        check(kind == HIT ? "hit_rsp_latency" : "miss_no_early_rsp", 32'(rsp_valid), 32'(kind == HIT));
        if (pf) begin
            n = 0;
            while (exp_q.size() != 0 && n < 500) begin @(negedge clk); #1; n++; end
            check("prefetch_blocks_req", 32'(req_ready), 32'd0);
        end
        wait_idle();
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        enable = 1'b1; prefetch_en = 1'b0; flush_valid = 1'b0;
        start_addr[0] = 32'h1000; end_addr[0] = 32'h2000;
        req_addr = '0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_flush_ready", 32'(flush_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_refill_valid", 32'(refill_valid), 32'd0);
        check("reset_refill_rsp_ready", 32'(refill_rsp_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);

        // Basic miss then hit
        rd(32'h1004, MISS, 1'b0, 1'b0);
        rd(32'h1008, HIT, 1'b0, 1'b0);
        check("hit_count_1", hit_count, 32'd1);
        check("miss_count_1", miss_count, 32'd1);

        // Non-cacheable bypass, never allocated
        rd(32'h3000, BYP, 1'b0, 1'b0);
        rd(32'h3000, BYP, 1'b0, 1'b0);
        check("bypass_hit_count", hit_count, 32'd1);
        check("bypass_miss_count", miss_count, 32'd1);

        // Round-robin eviction
        rd(32'h1010, MISS, 1'b0, 1'b0);
        rd(32'h1020, MISS, 1'b0, 1'b0);
        rd(32'h1030, MISS, 1'b0, 1'b0);
        rd(32'h1040, MISS, 1'b0, 1'b0);
        rd(32'h1000, MISS, 1'b0, 1'b0);
        rd(32'h1044, HIT, 1'b0, 1'b0);

        // Flush beats a simultaneous request
        exp_q.push_back({1'b0, 32'h1048}); exp_refill.push_back(32'h1040); exp_miss++;
        @(negedge clk); flush_valid = 1'b1; req_addr = 32'h1048; req_valid = 1'b1; #1;
        check("flush_ready_idle", 32'(flush_ready), 32'd1);
        check("flush_blocks_req", 32'(req_ready), 32'd0);
        @(negedge clk); flush_valid = 1'b0; #1;
        check("req_ready_after_flush", 32'(req_ready), 32'd1);
        @(negedge clk); req_valid = 1'b0;
        wait_idle();

        // Prefetch
        prefetch_en = 1'b1;
        rd(32'h1100, MISS, 1'b1, 1'b0);
        rd(32'h1114, HIT, 1'b0, 1'b0);
        rd(32'h1FF0, MISS, 1'b0, 1'b0);
        rd(32'h10F0, MISS, 1'b0, 1'b0);

        // Refill error: no allocation, no prefetch
        err_en = 1'b1; err_addr = 32'h1200;
        rd(32'h1204, MISS, 1'b0, 1'b1);
        rd(32'h1204, MISS, 1'b0, 1'b1);
        err_en = 1'b0;

        // Flush held off during a refill
        prefetch_en = 1'b0;
        exp_q.push_back({1'b0, 32'h1300}); exp_refill.push_back(32'h1300); exp_miss++;
        @(negedge clk); req_addr = 32'h1300; req_valid = 1'b1; #1;
        n = 0;
        while (!req_ready && n < 500) begin @(negedge clk); #1; n++; end
        @(negedge clk); req_valid = 1'b0; flush_valid = 1'b1; #1;
        check("flush_busy", 32'(flush_ready), 32'd0);
        n = 0;
        while (!flush_ready && n < 500) begin @(negedge clk); #1; n++; end
        check("flush_after_rsp", 32'(exp_q.size()), 32'd0);
        @(negedge clk); flush_valid = 1'b0;
        wait_idle();
        rd(32'h1304, MISS, 1'b0, 1'b0);

        // Disabled buffer bypasses a resident line
        enable = 1'b0;
        rd(32'h1300, BYP, 1'b0, 1'b0);
        enable = 1'b1;

        check("final_hit_count", hit_count, 32'(exp_hit));
        check("final_miss_count", miss_count, 32'(exp_miss));
        check("final_hit_const", hit_count, 32'd3);
        check("final_miss_const", miss_count, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
